ws281x_bit_ctrl: RTL and testbench

Upstream feeder for the ws281x_code bit encoder. Accepts pixel words over a valid/ready handshake and serializes each one MSB-first into single-bit requests (bit_rdy/bit_data). It waits for the encoder's bit_done before issuing the next bit. After the last pixel of a frame, it holds the line idle for a programmable latch (reset) period, then signals frame completion.

---
 rtl/ws281x_bit_ctrl.sv | 132 +++++++++++++
 tb/tb_ws281x_bit_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws281x_bit_ctrl.sv
// Serializes pixel words MSB-first into one-bit requests for the ws281x encoder, then holds a latch gap.
// Latency: bit_rdy_out one cycle after the accepting edge; pix_ready_out only in ACCEPT, each bit paced by bit_done_in.
module ws281x_bit_ctrl #(
    parameter int DATA_WIDTH      = 24,
    parameter int LATCH_CNT_WIDTH = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       pix_valid_in,
    input  logic [DATA_WIDTH-1:0]      pix_data_in,
    input  logic                       pix_last_in,
    output logic                       pix_ready_out,
    input  logic [LATCH_CNT_WIDTH-1:0] rst_cnt_in,
    input  logic                       bit_done_in,
    output logic                       bit_rdy_out,
    output logic                       bit_data_out,
    output logic                       busy_out,
    output logic                       frame_done_out
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LATCH  = 2'd3
    } state_t;

    state_t                     state_q,      state_d;
    logic [DATA_WIDTH-1:0]      shreg_q,      shreg_d;
    logic [CNT_W-1:0]           bit_cnt_q,    bit_cnt_d;
    logic                       last_q,       last_d;
    logic [LATCH_CNT_WIDTH-1:0] latch_cnt_q,  latch_cnt_d;
    logic                       bit_rdy_q,    bit_rdy_d;
    logic                       bit_data_q,   bit_data_d;
    logic                       busy_q,       busy_d;
    logic                       frame_done_q, frame_done_d;
    logic                       accept;

    assign pix_ready_out  = (state_q == ST_ACCEPT);
    assign accept         = pix_valid_in && pix_ready_out;
    assign bit_rdy_out    = bit_rdy_q;
    assign bit_data_out   = bit_data_q;
    assign busy_out       = busy_q;
    assign frame_done_out = frame_done_q;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        last_d       = last_q;
        latch_cnt_d  = latch_cnt_q;
        bit_rdy_d    = 1'b0;
        bit_data_d   = bit_data_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            ST_ACCEPT: begin
                if (accept) begin
                    shreg_d    = pix_data_in;
                    bit_cnt_d  = CNT_W'(DATA_WIDTH - 1);
                    last_d     = pix_last_in;
                    busy_d     = 1'b1;
                    bit_rdy_d  = 1'b1;
                    bit_data_d = pix_data_in[DATA_WIDTH-1];
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bit_done_in) begin
                    if (bit_cnt_q != '0) begin
                        // Next bit is presented straight from the pre-shift register.
                        shreg_d    = shreg_q << 1;
                        bit_cnt_d  = bit_cnt_q - 1'b1;
                        bit_rdy_d  = 1'b1;
                        bit_data_d = shreg_q[DATA_WIDTH-2];
                        state_d    = ST_SEND;
                    end else if (last_q) begin
                        // A zero latch request still holds the line for one cycle.
                        latch_cnt_d = (rst_cnt_in == '0) ? LATCH_CNT_WIDTH'(1) : rst_cnt_in;
                        state_d     = ST_LATCH;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end
            end
            ST_LATCH: begin
                if (latch_cnt_q == LATCH_CNT_WIDTH'(1)) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    last_d       = 1'b0;
                    state_d      = ST_ACCEPT;
                end else begin
                    latch_cnt_d = latch_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_ACCEPT;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            last_q       <= 1'b0;
            latch_cnt_q  <= '0;
            bit_rdy_q    <= 1'b0;
            bit_data_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            last_q       <= last_d;
            latch_cnt_q  <= latch_cnt_d;
            bit_rdy_q    <= bit_rdy_d;
            bit_data_q   <= bit_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_ws281x_bit_ctrl.sv
// Directed bench for ws281x_bit_ctrl with a 6-cycle encoder model and event logs.
module tb_ws281x_bit_ctrl;
    localparam int DW = 24;
    localparam int LW = 16;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          pix_valid_in;
    logic [DW-1:0] pix_data_in;
    logic          pix_last_in;
    logic          pix_ready_out;
    logic [LW-1:0] rst_cnt_in;
    logic          bit_done_in;
    logic          bit_rdy_out;
    logic          bit_data_out;
    logic          busy_out;
    logic          frame_done_out;

    ws281x_bit_ctrl #(.DATA_WIDTH(DW), .LATCH_CNT_WIDTH(LW)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .pix_valid_in(pix_valid_in), .pix_data_in(pix_data_in), .pix_last_in(pix_last_in),
        .pix_ready_out(pix_ready_out), .rst_cnt_in(rst_cnt_in),
        .bit_done_in(bit_done_in), .bit_rdy_out(bit_rdy_out), .bit_data_out(bit_data_out),
        .busy_out(busy_out), .frame_done_out(frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Encoder model: bit_done 6 cycles after each bit_rdy, plus optional injected pulses.
    int   pend = 0;
    logic enc_done = 1'b0;
    logic send_spur = 1'b0;
    logic send_spur_en = 1'b0;
    logic spur_done = 1'b0;
    assign bit_done_in = enc_done | send_spur | spur_done;

    logic bits_q[$];
    int   rdy_cyc[$];
    int   done_cyc[$];
    int   fd_cyc[$];
    int   dbl_err = 0;
    int   rb_cnt = 0;
    logic busy_prev = 1'b0;
    logic fd_busy = 1'b0, fd_busy_prev = 1'b0, fd_ready = 1'b0;

    always @(negedge clk_in) begin
        enc_done  = 1'b0;
        send_spur = 1'b0;
        if (pix_ready_out === 1'b1) pend = 0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                enc_done = 1'b1;
                done_cyc.push_back(cyc);
            end
        end
        if (bit_rdy_out === 1'b1) begin
            if (pend != 0) dbl_err++;
            bits_q.push_back(bit_data_out);
            rdy_cyc.push_back(cyc);
            pend = 6;
            if (send_spur_en) send_spur = 1'b1;
        end
        if (pix_ready_out === 1'b1 && busy_out === 1'b1) rb_cnt++;
        if (frame_done_out === 1'b1) begin
            fd_cyc.push_back(cyc);
            fd_busy      = busy_out;
            fd_busy_prev = busy_prev;
            fd_ready     = pix_ready_out;
        end
        busy_prev = busy_out;
    end

    function automatic int qget(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1000;
    endfunction

    function automatic logic [DW-1:0] bits_word(input int base);
        logic [DW-1:0] w = '0;
        for (int k = 0; k < DW; k++)
            w = {w[DW-2:0], (base + k < bits_q.size()) ? bits_q[base + k] : 1'bx};
        return w;
    endfunction

    function automatic int gap_errors();
        int e = 0;
        for (int i = 1; i < rdy_cyc.size(); i++)
            if (i % DW != 0 && rdy_cyc[i] != qget(done_cyc, i - 1) + 1) e++;
        return e;
    endfunction

    task automatic clear_logs();
        bits_q.delete(); rdy_cyc.delete(); done_cyc.delete(); fd_cyc.delete();
        dbl_err = 0; rb_cnt = 0;
    endtask

    task automatic send_pixel(input logic [DW-1:0] d, input logic l);
        int n = 0;
        while (pix_ready_out !== 1'b1 && n < 2000) begin @(negedge clk_in); n++; end
        vectors++;
        if (pix_ready_out !== 1'b1) begin
            miscompares++;
            $display("FAIL send_ready pix_ready=%b required 1", pix_ready_out);
        end
        pix_valid_in = 1'b1; pix_data_in = d; pix_last_in = l;
        @(negedge clk_in);
        pix_valid_in = 1'b0; pix_last_in = 1'b0;
    endtask

    task automatic wait_frame(input int n, input string name);
        int t = 0;
        while (fd_cyc.size() < n && t < 3000) begin @(negedge clk_in); t++; end
        vectors++;
        if (fd_cyc.size() < n) begin
            miscompares++;
            $display("FAIL %s_timeout frame_done count=%0d required %0d", name, fd_cyc.size(), n);
        end
        repeat (3) @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        vectors += 5;
        if (bit_rdy_out !== 1'b0) begin miscompares++; $display("FAIL rst_bit_rdy got=%b exp=0", bit_rdy_out); end
        if (bit_data_out !== 1'b0) begin miscompares++; $display("FAIL rst_bit_data got=%b exp=0", bit_data_out); end
        if (busy_out !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy_out); end
        if (frame_done_out !== 1'b0) begin miscompares++; $display("FAIL rst_frame_done got=%b exp=0", frame_done_out); end
        if (pix_ready_out !== 1'b1) begin miscompares++; $display("FAIL rst_pix_ready got=%b exp=1", pix_ready_out); end
        rst_n_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_single_pixel();
        clear_logs();
        rst_cnt_in = 16'd10;
        send_pixel(24'hA50F81, 1'b1);
        vectors += 3;
        if (bit_rdy_out !== 1'b1) begin miscompares++; $display("FAIL single_latency bit_rdy got=%b exp=1", bit_rdy_out); end
        if (busy_out !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%b exp=1", busy_out); end
        if (pix_ready_out !== 1'b0) begin miscompares++; $display("FAIL single_ready_low got=%b exp=0", pix_ready_out); end
        wait_frame(1, "single");
        vectors += 8;
        if (bits_q.size() != 24) begin miscompares++; $display("FAIL single_nbits got=%0d exp=24", bits_q.size()); end
        if (bits_word(0) !== 24'hA50F81) begin miscompares++; $display("FAIL single_bits got=%h exp=a50f81", bits_word(0)); end
        if (gap_errors() != 0) begin miscompares++; $display("FAIL single_gap got=%0d exp=0", gap_errors()); end
        if (dbl_err != 0) begin miscompares++; $display("FAIL single_double_rdy got=%0d exp=0", dbl_err); end
        if (qget(fd_cyc, 0) - qget(done_cyc, 23) != 11) begin
            miscompares++; $display("FAIL single_latch_time got=%0d exp=11", qget(fd_cyc, 0) - qget(done_cyc, 23));
        end
        if (fd_busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_fall got=%b exp=0", fd_busy); end
        if (fd_busy_prev !== 1'b1) begin miscompares++; $display("FAIL single_busy_before got=%b exp=1", fd_busy_prev); end
        if (fd_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready_rise got=%b exp=1", fd_ready); end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        rst_cnt_in = 16'd4;
        send_pixel(24'hFFFFFF, 1'b0);
        send_pixel(24'h000000, 1'b0);
        send_pixel(24'h123456, 1'b1);
        wait_frame(1, "b2b");
        vectors += 8;
        if (bits_q.size() != 72) begin miscompares++; $display("FAIL b2b_nbits got=%0d exp=72", bits_q.size()); end
        if (bits_word(0) !== 24'hFFFFFF) begin miscompares++; $display("FAIL b2b_pix0 got=%h exp=ffffff", bits_word(0)); end
        if (bits_word(24) !== 24'h000000) begin miscompares++; $display("FAIL b2b_pix1 got=%h exp=000000", bits_word(24)); end
        if (bits_word(48) !== 24'h123456) begin miscompares++; $display("FAIL b2b_pix2 got=%h exp=123456", bits_word(48)); end
        if (rb_cnt != 2) begin miscompares++; $display("FAIL b2b_ready_gaps got=%0d exp=2", rb_cnt); end
        if (qget(rdy_cyc, 24) - qget(done_cyc, 23) != 2) begin
            miscompares++; $display("FAIL b2b_pixel_gap got=%0d exp=2", qget(rdy_cyc, 24) - qget(done_cyc, 23));
        end
        if (fd_cyc.size() != 1) begin miscompares++; $display("FAIL b2b_nframes got=%0d exp=1", fd_cyc.size()); end
        if (qget(fd_cyc, 0) - qget(done_cyc, 71) != 5) begin
            miscompares++; $display("FAIL b2b_latch_time got=%0d exp=5", qget(fd_cyc, 0) - qget(done_cyc, 71));
        end
    endtask

    task automatic test_zero_latch();
        clear_logs();
        rst_cnt_in = 16'd0;
        send_pixel(24'h000001, 1'b1);
        wait_frame(1, "zero");
        vectors += 2;
        if (bits_word(0) !== 24'h000001) begin miscompares++; $display("FAIL zero_bits got=%h exp=000001", bits_word(0)); end
        if (qget(fd_cyc, 0) - qget(done_cyc, 23) != 2) begin
            miscompares++; $display("FAIL zero_latch_time got=%0d exp=2", qget(fd_cyc, 0) - qget(done_cyc, 23));
        end
    endtask

    task automatic test_spurious();
        int t = 0;
        clear_logs();
        rst_cnt_in = 16'd3;
        spur_done = 1'b1;
        @(negedge clk_in);
        spur_done = 1'b0;
        @(negedge clk_in);
        vectors += 2;
        if (bit_rdy_out !== 1'b0) begin miscompares++; $display("FAIL spur_accept_rdy got=%b exp=0", bit_rdy_out); end
        if (pix_ready_out !== 1'b1) begin miscompares++; $display("FAIL spur_accept_ready got=%b exp=1", pix_ready_out); end
        send_spur_en = 1'b1;
        send_pixel(24'hA50F81, 1'b1);
        while (done_cyc.size() < 24 && t < 2000) begin @(negedge clk_in); t++; end
        @(negedge clk_in);
        spur_done = 1'b1;
        @(negedge clk_in);
        spur_done = 1'b0;
        send_spur_en = 1'b0;
        wait_frame(1, "spur");
        vectors += 5;
        if (bits_q.size() != 24) begin miscompares++; $display("FAIL spur_nbits got=%0d exp=24", bits_q.size()); end
        if (bits_word(0) !== 24'hA50F81) begin miscompares++; $display("FAIL spur_bits got=%h exp=a50f81", bits_word(0)); end
        if (dbl_err != 0) begin miscompares++; $display("FAIL spur_double_rdy got=%0d exp=0", dbl_err); end
        if (fd_cyc.size() != 1) begin miscompares++; $display("FAIL spur_nframes got=%0d exp=1", fd_cyc.size()); end
        if (qget(fd_cyc, 0) - qget(done_cyc, 23) != 4) begin
            miscompares++; $display("FAIL spur_latch_time got=%0d exp=4", qget(fd_cyc, 0) - qget(done_cyc, 23));
        end
    endtask

    task automatic test_mid_reset();
        int t = 0;
        int fd_before;
        clear_logs();
        rst_cnt_in = 16'd5;
        send_pixel(24'hC3C3C3, 1'b1);
        while (rdy_cyc.size() < 8 && t < 2000) begin @(negedge clk_in); t++; end
        rst_n_in = 1'b0;
        @(negedge clk_in);
        vectors += 5;
        if (bit_rdy_out !== 1'b0) begin miscompares++; $display("FAIL mrst_bit_rdy got=%b exp=0", bit_rdy_out); end
        if (bit_data_out !== 1'b0) begin miscompares++; $display("FAIL mrst_bit_data got=%b exp=0", bit_data_out); end
        if (busy_out !== 1'b0) begin miscompares++; $display("FAIL mrst_busy got=%b exp=0", busy_out); end
        if (frame_done_out !== 1'b0) begin miscompares++; $display("FAIL mrst_frame_done got=%b exp=0", frame_done_out); end
        if (pix_ready_out !== 1'b1) begin miscompares++; $display("FAIL mrst_pix_ready got=%b exp=1", pix_ready_out); end
        rst_n_in = 1'b1;
        fd_before = fd_cyc.size();
        repeat (30) @(negedge clk_in);
        vectors++;
        if (fd_cyc.size() != 0) begin
            miscompares++; $display("FAIL mrst_no_frame got=%0d exp=0 (before=%0d)", fd_cyc.size(), fd_before);
        end
        clear_logs();
        send_pixel(24'h5A5A5A, 1'b1);
        wait_frame(1, "mrst");
        vectors += 3;
        if (bits_q.size() != 24) begin miscompares++; $display("FAIL mrst_nbits got=%0d exp=24", bits_q.size()); end
        if (bits_word(0) !== 24'h5A5A5A) begin miscompares++; $display("FAIL mrst_bits got=%h exp=5a5a5a", bits_word(0)); end
        if (qget(fd_cyc, 0) - qget(done_cyc, 23) != 6) begin
            miscompares++; $display("FAIL mrst_latch_time got=%0d exp=6", qget(fd_cyc, 0) - qget(done_cyc, 23));
        end
    endtask

    initial begin
        rst_n_in     = 1'b0;
        pix_valid_in = 1'b0;
        pix_data_in  = '0;
        pix_last_in  = 1'b0;
        rst_cnt_in   = '0;
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_zero_latch();
        test_spurious();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
